// File: rtl/latch_dump_sequencer_pkg.sv
// Shared debug package: dump-sequencer state encoding and the frame-start
// marker, reused by the loader and the UART-side debug blocks.
package latch_dump_sequencer_pkg;

  // Sequencer states
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_SEND      = 2'd1;
  localparam logic [1:0] ST_WAIT_DONE = 2'd2;
  localparam logic [1:0] ST_FINISH    = 2'd3;

  // Marker byte that opens every dump frame
  localparam logic [7:0] DEFAULT_HEADER_BYTE = 8'hA5;

  // Width of a byte index that must reach nb_bytes without wrapping
  function automatic int idx_width(input int nb_bytes);
    return (nb_bytes < 1) ? 1 : $clog2(nb_bytes + 1);
  endfunction

endpackage

// File: rtl/latch_dump_sequencer.sv
// Latch dump sequencer: on a start request, freezes a snapshot of the
// pipeline registers and streams it to a UART transmitter as a header byte
// followed by the snapshot bytes, LSB byte first. While the frame is in
// flight it asks for the MIPS clock to be held.
module latch_dump_sequencer
  import latch_dump_sequencer_pkg::*;
#(
  parameter int                       NBIT_DATA_LEN = 8,
  parameter int                       NB_DUMP_BYTES = 16,
  parameter logic [NBIT_DATA_LEN-1:0] HEADER_BYTE   = DEFAULT_HEADER_BYTE
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic [NB_DUMP_BYTES*NBIT_DATA_LEN-1:0] snapshot_in,
  input  logic                                    tx_done_tick,
  output logic                                    tx_start,
  output logic [NBIT_DATA_LEN-1:0]                data_out,
  output logic                                    busy,
  output logic                                    hold_mips,
  output logic                                    done
);

  localparam int                IDX_W    = idx_width(NB_DUMP_BYTES);
  localparam int                SNAP_W   = NB_DUMP_BYTES * NBIT_DATA_LEN;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NB_DUMP_BYTES);

  logic [1:0]               r_state;
  logic [IDX_W-1:0]         r_index;
  logic [SNAP_W-1:0]        r_shadow;
  logic [NBIT_DATA_LEN-1:0] r_data;

  logic [NBIT_DATA_LEN-1:0] w_next_byte;

  // Payload byte addressed by the current index; only consumed while the
  // index is still below NB_DUMP_BYTES, so it never reads past the shadow.
  assign w_next_byte = r_shadow[int'(r_index) * NBIT_DATA_LEN +: NBIT_DATA_LEN];

  // Frame sequencing: capture, send one byte, wait for the UART, repeat
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values and the order of statements is irrelevant.
    if (reset) begin
      r_state  <= ST_IDLE;
      r_index  <= '0;
      r_shadow <= '0;
      r_data   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_shadow <= snapshot_in;
            r_index  <= '0;
            r_data   <= HEADER_BYTE;
            r_state  <= ST_SEND;
          end
        end
        ST_SEND: begin
          r_state <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          if (tx_done_tick) begin
            if (r_index < LAST_IDX) begin
              r_data  <= w_next_byte;
              r_index <= r_index + 1'b1;
              r_state <= ST_SEND;
            end else begin
              r_state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Outputs decode registered state only, so no input reaches an output
  // combinationally.
  assign tx_start  = (r_state == ST_SEND);
  assign done      = (r_state == ST_FINISH);
  assign busy      = (r_state != ST_IDLE);
  assign hold_mips = (r_state != ST_IDLE);
  assign data_out  = r_data;

endmodule

// File: tb/tb_latch_dump_sequencer.sv
// Bench for latch_dump_sequencer with a 4-byte snapshot. A simple UART model
// answers each tx_start with tx_done_tick after a programmable delay; a
// monitor pops expected frame bytes from a queue on every tx_start.
module tb_latch_dump_sequencer;

  localparam int NB = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [NB*8-1:0] snapshot_in;
  logic          tx_done_tick;
  logic          tx_start;
  logic [7:0]    data_out;
  logic          busy;
  logic          hold_mips;
  logic          done;

  logic          uart_tick = 1'b0;
  logic          man_tick  = 1'b0;
  int            uart_delay = 10;
  int            uart_cnt   = 0;

  int            n_tests = 0;
  int            n_fail  = 0;
  int            n_tx    = 0;
  int            n_done  = 0;
  int            cycle   = 0;
  logic [7:0]    last_byte = 8'h00;

  logic [7:0]    exp_q[$];
  int            tx_cyc_q[$];
  int            done_cyc_q[$];

  assign tx_done_tick = uart_tick | man_tick;

  always #5 clk = ~clk;

  latch_dump_sequencer #(
    .NBIT_DATA_LEN (8),
    .NB_DUMP_BYTES (NB),
    .HEADER_BYTE   (8'hA5)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .snapshot_in  (snapshot_in),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .data_out     (data_out),
    .busy         (busy),
    .hold_mips    (hold_mips),
    .done         (done)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // UART model: tx_done_tick uart_delay cycles after each tx_start
  always @(negedge clk) begin
    uart_tick = 1'b0;
    if (uart_cnt != 0) begin
      uart_cnt--;
      if (uart_cnt == 0) uart_tick = 1'b1;
    end
    if (tx_start) uart_cnt = uart_delay;
  end

  // Monitor: scoreboard pop on every transmitted byte, hold checks otherwise
  always @(negedge clk) begin
    cycle++;
    if (tx_start) begin
      n_tx++;
      tx_cyc_q.push_back(cycle);
      check("tx_busy_hold", {30'd0, busy, hold_mips}, 32'd3);
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_tx: got byte %0h, expected no transmit", data_out);
      end else begin
        check("frame_byte", {24'd0, data_out}, {24'd0, exp_q.pop_front()});
      end
      last_byte = data_out;
    end else if (busy) begin
      check("data_hold", {24'd0, data_out}, {24'd0, last_byte});
    end
    if (done) begin
      n_done++;
      done_cyc_q.push_back(cycle);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic push_frame(input logic [NB*8-1:0] snap);
    exp_q.push_back(8'hA5);
    for (int i = 0; i < NB; i++) exp_q.push_back(snap[i*8 +: 8]);
  endtask

  task automatic wait_tx(input int target, input int budget);
    int k = 0;
    while (n_tx < target && k < budget) begin
      step(1);
      k++;
    end
    if (n_tx < target) check("wait_tx_timeout", n_tx, target);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      step(1);
      k++;
    end
    if (n_done < target) check("wait_done_timeout", n_done, target);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask

  task automatic finish_frame(input int base_tx, input int base_done, input logic [7:0] last);
    wait_done(base_done + 1, 400);
    step(3);
    check("tx_count",    n_tx - base_tx, 5);
    check("done_count",  n_done - base_done, 1);
    check("busy_after",  busy, 0);
    check("hold_after",  hold_mips, 0);
    check("idle_data",   data_out, last);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b_tx;
    int b_done;

    reset = 1'b1;
    start = 1'b0;
    snapshot_in = '0;
    step(3);
    check("rst_tx_start", tx_start, 0);
    check("rst_data_out", data_out, 0);
    check("rst_busy",     busy, 0);
    check("rst_hold",     hold_mips, 0);
    check("rst_done",     done, 0);
    reset = 1'b0;
    step(2);

    // Basic frame
    b_tx = n_tx; b_done = n_done;
    snapshot_in = 32'h11223344;
    push_frame(32'h11223344);
    pulse_start();
    check("first_tx_next_cycle", tx_start, 1);
    check("busy_in_frame", busy, 1);
    finish_frame(b_tx, b_done, 8'h11);

    // Snapshot changes right after capture
    b_tx = n_tx; b_done = n_done;
    snapshot_in = 32'h11223344;
    push_frame(32'h11223344);
    pulse_start();
    snapshot_in = 32'hDEADBEEF;
    finish_frame(b_tx, b_done, 8'h11);

    // Start re-pulsed mid-frame
    b_tx = n_tx; b_done = n_done;
    snapshot_in = 32'hA1B2C3D4;
    push_frame(32'hA1B2C3D4);
    pulse_start();
    wait_tx(b_tx + 3, 200);
    step(4);
    check("in_wait_done", {30'd0, busy, tx_start}, 32'd2);
    pulse_start();
    finish_frame(b_tx, b_done, 8'hA1);
    step(20);
    check("no_requeued_frame", n_tx - b_tx, 5);

    // Reset mid-frame, with start and tick in the same cycle, then a late tick
    b_tx = n_tx; b_done = n_done;
    snapshot_in = 32'h55667788;
    push_frame(32'h55667788);
    pulse_start();
    wait_tx(b_tx + 4, 200);
    step(3);
    reset = 1'b1; start = 1'b1; man_tick = 1'b1;
    step(1);
    man_tick = 1'b0;
    step(1);
    reset = 1'b0; start = 1'b0;
    exp_q.delete();
    check("abort_tx_start", tx_start, 0);
    check("abort_busy",     busy, 0);
    check("abort_hold",     hold_mips, 0);
    check("abort_data",     data_out, 0);
    b_tx = n_tx;
    man_tick = 1'b1;
    step(1);
    man_tick = 1'b0;
    step(25);
    check("abort_no_tx",   n_tx - b_tx, 0);
    check("abort_no_done", n_done - b_done, 0);
    check("abort_idle",    busy, 0);
    check("abort_data2",   data_out, 0);

    // Tick while idle, then a normal frame
    b_tx = n_tx; b_done = n_done;
    man_tick = 1'b1;
    step(1);
    man_tick = 1'b0;
    step(5);
    check("idle_tick_no_tx", n_tx - b_tx, 0);
    check("idle_tick_busy",  busy, 0);
    snapshot_in = 32'h01234567;
    push_frame(32'h01234567);
    pulse_start();
    finish_frame(b_tx, b_done, 8'h01);

    // Start held high, prompt UART: back-to-back frames
    uart_delay = 1;
    b_tx = n_tx; b_done = n_done;
    snapshot_in = 32'hCAFEF00D;
    push_frame(32'hCAFEF00D);
    push_frame(32'h0BADC0DE);
    start = 1'b1;
    step(1);
    snapshot_in = 32'h0BADC0DE;
    wait_done(b_done + 1, 100);
    step(2);
    check("b2b_second_send", tx_start, 1);
    start = 1'b0;
    wait_done(b_done + 2, 100);
    step(5);
    check("b2b_tx_count",   n_tx - b_tx, 10);
    check("b2b_done_count", n_done - b_done, 2);
    if (tx_cyc_q.size() > b_tx + 5 && done_cyc_q.size() > b_done)
      check("b2b_idle_gap", tx_cyc_q[b_tx + 5] - done_cyc_q[b_done], 2);
    else
      check("b2b_cycles_recorded", tx_cyc_q.size(), b_tx + 10);
    check("b2b_last_byte", data_out, 8'h0B);
    check("b2b_busy",      busy, 0);
    check("b2b_queue",     exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
